mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store port: accepts one word, halfword or byte request at a time and returns a single-cycle response after a fixed wait.
- Sub-word stores are done internally by read-modify-write, so the CPU does not merge bytes itself.
- Sits between the CPU datapath (address from the IorD path, store data from the BWD path) and a DEPTH-word on-chip storage array.
- Response latency matches the CPU control unit's wait-state counting.

Parameters:
- DEPTH, 256, number of 32-bit words in storage; power of two.
- LATENCY, 2, wait cycles between request acceptance and the storage access; legal range 1..15.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder idle; a request is accepted on an edge where req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified (half in [15:0], byte in [7:0]).
- rsp_valid  output  1  one-cycle response strobe; no backpressure.
- rsp_rdata  output  32  load data, zero-extended and right-justified; 0 for stores.
- rsp_err  output  1  request faulted; valid only with rsp_valid.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - Any in-flight request is dropped and its pending write is discarded.
  - Storage contents are not cleared.
- States: IDLE, WAIT, ACCESS, MERGE, RESP.
  - req_ready = 1 only in IDLE.
  - rsp_valid = 1 only in RESP.
- IDLE: on acceptance, latch we/size/addr/wdata, load counter with LATENCY-1, go to WAIT.
- WAIT: decrement the counter each cycle; at 0 go to ACCESS. WAIT therefore lasts exactly LATENCY cycles.
- ACCESS: synchronous read of word addr[log2(DEPTH)+1:2] into the data register.
  - Word store: write req_wdata on this edge, go to RESP.
  - Half or byte store: go to MERGE.
  - Load: go to RESP.
- MERGE: write the old word with the selected lane replaced, go to RESP.
  - Lanes are little-endian: byte offset 0 = bits [7:0]; half offset 0 = [15:0], offset 2 = [31:16].
- RESP: drive the response for one cycle, then return to IDLE. Back-to-back requests are therefore separated by at least one idle cycle.
- Load data extraction: the lane selected by addr[1:0] is placed in the low bits and zero-extended. Sign extension belongs to the CPU.
- Latency, with acceptance edge = edge 0:
  - Load or word store: rsp_valid high between edges LATENCY+1 and LATENCY+2.
  - Sub-word store: one cycle later.
- Requests arriving while req_ready = 0 are ignored; the requester must hold them.
- Fault conditions (see Optional Feature): misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) or out-of-range access (addr >= 4*DEPTH).
- Read-after-write: a load issued after a store's response returns the stored value (no bypass is needed).

Optional Feature:
- Macro: MEMRESP_ERR_EN.
- Defined:
  - A faulting request still takes full latency and responds with rsp_err = 1 and rsp_rdata = 0.
  - Storage is never written on a faulting store.
- Undefined:
  - rsp_err is tied to 0.
  - Address bits above the word index are ignored (wrap modulo 4*DEPTH).
  - Misaligned addresses are forced aligned by clearing addr[1:0] for word and addr[0] for half.

Decomposition:
- Package memresp_pkg:
  - size_t enum (SZ_WORD, SZ_HALF, SZ_BYTE).
  - state_t enum (five states).
  - Localparam for the wait-counter width (4).
- Sub-module memresp_lane: combinational lane extract (load) and lane merge (store) from size and addr[1:0]. It is instantiated once, so the FSM module holds only control and storage.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10, then load 0x10 -> each rsp_valid appears 3 edges after acceptance (LATENCY = 2); the load returns 0xDEADBEEF with rsp_err = 0.
- Byte merge: store byte 0xAA at 0x11 over word 0x11223344 -> word becomes 0x1122AA44; the store response comes 4 edges after acceptance; a byte load at 0x11 returns 0x000000AA.
- Half merge: store half 0xBEEF at 0x12 over 0x11223344 -> 0xBEEF3344; a half load at 0x12 returns 0x0000BEEF.
- Misaligned and out of range, MEMRESP_ERR_EN defined: word store at 0x13 -> rsp_err = 1 and the word at 0x10 is unchanged; load at 0x400 (DEPTH = 256) -> rsp_err = 1, rsp_rdata = 0.
- Same faulting stimulus, macro undefined: word store at 0x13 writes 0x10; load at 0x400 returns the word at 0x0.
- Reset mid-operation: assert reset low during MERGE of a byte store -> req_ready = 1 and rsp_valid = 0 immediately; the target word is unchanged after reset is released; the next request is accepted normally.

Source files
------------

// File: rtl/memresp_pkg.sv
// Shared types for the memory responder.
//   size_t      : request size after decoding (reserved size maps to word)
//   state_t     : responder FSM states
//   CNT_W       : width of the wait-state counter (LATENCY up to 15)
//   decode_size : maps the raw 2-bit req_size onto size_t
package memresp_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } state_t;

  function automatic size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_BYTE;
      default: return SZ_WORD;  // 11 is reserved and behaves as a word
    endcase
  endfunction

endpackage

// File: rtl/memresp_lane.sv
// Combinational lane logic for the memory responder.
//   size   : decoded access size
//   off    : byte offset within the word (already aligned as required)
//   word   : word read from storage
//   wdata  : right-justified store data
//   rdata  : selected lane, right-justified and zero-extended (loads)
//   merged : word with the selected lane replaced by wdata (stores)
// Lanes are little-endian: offset 0 is bits [7:0].
module memresp_lane
  import memresp_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    rdata  = word;
    merged = wdata;
    case (size)
      SZ_HALF: begin
        merged = word;
        if (off[1]) begin
          rdata          = {16'h0, word[31:16]};
          merged[31:16]  = wdata[15:0];
        end else begin
          rdata          = {16'h0, word[15:0]};
          merged[15:0]   = wdata[15:0];
        end
      end
      SZ_BYTE: begin
        merged                 = word;
        rdata                  = {24'h0, word[{off, 3'b000} +: 8]};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      default: begin
        rdata  = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU load/store port.
// One request at a time; response strobe after LATENCY wait cycles plus
// the storage access (and one more cycle for sub-word read-modify-write).
//   clock, reset           : clock, async active-low reset
//   req_valid/req_ready    : request handshake (ready only when idle)
//   req_we/size/addr/wdata : request fields (size 11 treated as word)
//   rsp_valid              : one-cycle response strobe
//   rsp_rdata              : zero-extended load data, 0 for stores/faults
//   rsp_err                : fault flag (only with MEMRESP_ERR_EN)
// Build option MEMRESP_ERR_EN: misaligned or out-of-range requests fault
// (no write, rdata 0, err 1). Without it, addresses wrap and misaligned
// word/half addresses are forced aligned.
module mem_responder
  import memresp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  size_t              size_q, size_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        data_q;

  logic [31:0]        mem [DEPTH];
  logic               mem_we, mem_re;
  logic [31:0]        lane_rdata, lane_merged;

  size_t              acc_size;
  logic [1:0]         acc_off;
  logic               acc_err;

  // Request decode at acceptance: offset normalisation and fault detection.
  always_comb begin
    acc_size = decode_size(req_size);
    acc_off  = req_addr[1:0];
`ifdef MEMRESP_ERR_EN
    acc_err  = (|req_addr[31:AW+2]) ||
               (acc_size == SZ_WORD && |req_addr[1:0]) ||
               (acc_size == SZ_HALF && req_addr[0]);
`else
    acc_err  = 1'b0;
    if (acc_size == SZ_WORD) acc_off    = 2'b00;
    if (acc_size == SZ_HALF) acc_off[0] = 1'b0;
`endif
  end

`ifndef MEMRESP_ERR_EN
  // Address bits above the word index are deliberately ignored (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[31:AW+2];
`endif

  memresp_lane u_lane (
    .size   (size_q),
    .off    (off_q),
    .word   (data_q),
    .wdata  (wdata_q),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = acc_size;
          idx_d   = req_addr[AW+1:2];
          off_d   = acc_off;
          wdata_d = req_wdata;
          err_d   = acc_err;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        mem_re = 1'b1;
        // Word stores write directly; lane_merged passes wdata through.
        if (we_q && size_q == SZ_WORD) begin
          mem_we  = !err_q;
          state_d = ST_RESP;
        end else if (we_q) begin
          state_d = ST_MERGE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_MERGE: begin
        mem_we  = !err_q;
        state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset. Writes are gated by the registered state, so a
  // reset during MERGE leaves the target word untouched.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= lane_merged;
    if (mem_re) data_q     <= mem[idx_q];
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? lane_rdata : 32'h0;

endmodule
